// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: raster pixel counter and window-valid/coordinate tracker for a KxK sliding-window FIFO.
module conv_window_ctrl #(
   parameter int IFM_SIZE = 28,
   parameter int KERNAL_SIZE = 5,
   localparam int OUT_SIZE = IFM_SIZE - KERNAL_SIZE + 1,
   localparam int CW = $clog2(IFM_SIZE),
   localparam int OW = $clog2(OUT_SIZE * OUT_SIZE + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          fifo_enable,
   input  logic          mac_ready,
   output logic          window_valid,
   output logic [CW-1:0] out_row,
   output logic [CW-1:0] out_col,
   output logic [OW-1:0] out_count,
   output logic          busy,
   output logic          done
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam logic [CW-1:0] LAST = CW'(IFM_SIZE - 1);
   localparam logic [CW-1:0] EDGE = CW'(KERNAL_SIZE - 1);
   state_t state;
   logic [CW-1:0] pix_row, pix_col;
   logic accept, new_win, last_pix;
   // a pending unconsumed window blocks shifting so its taps stay intact
   assign in_ready = (state == RUN) & ~(window_valid & ~mac_ready);
   assign fifo_enable = in_valid & in_ready;
   assign accept = window_valid & mac_ready;
   assign new_win = fifo_enable & (pix_row >= EDGE) & (pix_col >= EDGE);
   assign last_pix = fifo_enable & (pix_row == LAST) & (pix_col == LAST);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         pix_row <= '0;
         pix_col <= '0;
         out_count <= '0;
         window_valid <= 1'b0;
         out_row <= '0;
         out_col <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (fifo_enable) begin
            pix_col <= (pix_col == LAST) ? '0 : pix_col + CW'(1);
            if (pix_col == LAST) pix_row <= pix_row + CW'(1);
         end
         if (accept) out_count <= out_count + OW'(1);
         if (new_win) begin
            window_valid <= 1'b1;
            out_row <= pix_row - EDGE;
            out_col <= pix_col - EDGE;
         end else if (accept)
            window_valid <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  state <= RUN;
                  busy <= 1'b1;
                  pix_row <= '0;
                  pix_col <= '0;
                  out_count <= '0;
               end
            RUN: if (last_pix) state <= DRAIN;
            DRAIN:
               if (accept) begin
                  state <= DONE;
                  busy <= 1'b0;
                  done <= 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: scoreboard bench; expected window coordinates are queued per shift and popped on MAC acceptance.
module tb_conv_window_ctrl;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, mac_ready = 1'b0;
   logic in_ready, fifo_enable, window_valid, busy, done;
   logic [4:0] out_row, out_col;
   logic [9:0] out_count;
   int checks = 0, errors = 0;
   int exp_q[$];
   int mrow, mcol, shifts, acc_cnt, first_at, done_oc, done_busy;
   bit seen_first, done_seen;

   conv_window_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .fifo_enable(fifo_enable), .mac_ready(mac_ready), .window_valid(window_valid),
      .out_row(out_row), .out_col(out_col), .out_count(out_count), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // monitor: every presented window must match the oldest expected coordinate (row*32+col)
   always @(negedge clk)
      if (window_valid) begin
         if (exp_q.size() == 0)
            chk("spurious_window", int'({out_row, out_col}), -1);
         else begin
            chk("window_coord", int'({out_row, out_col}), exp_q[0]);
            if (mac_ready) begin
               void'(exp_q.pop_front());
               acc_cnt++;
            end
         end
      end

   task automatic cyc(input logic iv, input logic mr, input logic st);
      @(posedge clk);
      #1;
      in_valid = iv;
      mac_ready = mr;
      start = st;
      @(negedge clk);
      if (window_valid && !seen_first) begin
         seen_first = 1'b1;
         first_at = shifts;
      end
      if (done) begin
         done_seen = 1'b1;
         done_oc = out_count;
         done_busy = busy;
      end
      if (fifo_enable) begin
         if (mrow >= 4 && mcol >= 4) exp_q.push_back((mrow - 4) * 32 + (mcol - 4));
         shifts++;
         if (mcol == 27) begin
            mcol = 0;
            mrow++;
         end else
            mcol++;
      end
   endtask

   task automatic chk_reset_outputs();
      chk("reset_in_ready", in_ready, 0);
      chk("reset_fifo_enable", fifo_enable, 0);
      chk("reset_window_valid", window_valid, 0);
      chk("reset_out_row", out_row, 0);
      chk("reset_out_col", out_col, 0);
      chk("reset_out_count", out_count, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
   endtask

   task automatic start_image();
      mrow = 0;
      mcol = 0;
      shifts = 0;
      acc_cnt = 0;
      first_at = -1;
      seen_first = 1'b0;
      done_seen = 1'b0;
      cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      chk("busy_after_start", busy, 1);
   endtask

   task automatic run_until_done(input int ivp, input int mrp, input bit tail);
      for (int i = 0; i < 20000 && !done_seen; i++)
         cyc($urandom_range(99) < ivp, $urandom_range(99) < mrp, 1'b0);
      if (!done_seen)
         chk("done_timeout", 0, 1);
      else begin
         chk("first_window_after_shifts", first_at, 117);
         chk("windows_accepted", acc_cnt, 576);
         chk("out_count_at_done", done_oc, 576);
         chk("busy_at_done", done_busy, 0);
         chk("total_shifts", shifts, 784);
         chk("scoreboard_empty", exp_q.size(), 0);
      end
      if (tail) begin
         cyc(1'b0, 1'b1, 1'b0);
         chk("done_one_cycle", done, 0);
         chk("idle_not_busy", busy, 0);
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b1;
      mac_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         chk("idle_no_shift", fifo_enable, 0);
      end
      // full-rate image
      start_image();
      run_until_done(100, 100, 1'b1);
      // backpressure on the first window
      start_image();
      for (int i = 0; i < 200 && !window_valid; i++) cyc(1'b1, 1'b0, 1'b0);
      chk("bp_first_window", first_at, 117);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_fifo_enable", fifo_enable, 0);
         chk("bp_valid_held", window_valid, 1);
         chk("bp_coord_held", int'({out_row, out_col}), 0);
         chk("bp_count_held", out_count, 0);
      end
      cyc(1'b1, 1'b1, 1'b0);
      chk("bp_resume_shift", fifo_enable, 1);
      cyc(1'b1, 1'b1, 1'b0);
      chk("bp_count_after_accept", out_count, 1);
      run_until_done(100, 100, 1'b1);
      // random input and MAC gaps
      start_image();
      run_until_done(50, 70, 1'b1);
      // reset in the middle of an image
      start_image();
      for (int i = 0; i < 2000 && shifts < 300; i++) cyc($urandom_range(99) < 50, 1'b1, 1'b0);
      chk("mid_image_shifts", shifts, 300);
      cyc(1'b0, 1'b1, 1'b0);
      #2;
      in_valid = 1'b1;
      reset = 1'b1;
      #1;
      chk_reset_outputs();
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         chk("post_reset_no_shift", fifo_enable, 0);
      end
      start_image();
      run_until_done(100, 100, 1'b1);
      // start pulses during RUN, then back-to-back images
      start_image();
      for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, (i % 10) == 3);
      chk("start_in_run_busy", busy, 1);
      run_until_done(100, 100, 1'b0);
      start_image();
      run_until_done(100, 100, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameter IFM_SIZE, default 28, input feature map width/height in pixels.
REQ-002 Parameter KERNAL_SIZE, default 5, convolution window edge.
REQ-003 Derived: OUT_SIZE = IFM_SIZE-KERNAL_SIZE+1; CW = $clog2(IFM_SIZE); OW = $clog2(OUT_SIZE*OUT_SIZE+1).
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 start  input  1  begin one image; sampled only in IDLE.
REQ-007 in_valid  input  1  upstream pixel available.
REQ-008 in_ready  output  1  controller accepts pixel this cycle.
REQ-009 fifo_enable  output  1  shift strobe to window FIFO, combinational = in_valid & in_ready.
REQ-010 mac_ready  input  1  downstream MAC consumes current window.
REQ-011 window_valid  output  1  FIFO's 25 taps hold a complete, non-wrapping window.
REQ-012 out_row, out_col  output  CW each  output-map coordinate of current window.
REQ-013 out_count  output  OW  windows accepted by MAC this image.
REQ-014 busy  output  1  high in RUN or DRAIN.
REQ-015 done  output  1  one-cycle pulse at image completion.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN, DONE; encoding free.
REQ-017 IDLE -> RUN on start; clears pix_row, pix_col, out_count to 0; start in any other state ignored.
REQ-018 in_ready = (state==RUN) & ~(window_valid & ~mac_ready); 0 in IDLE, DRAIN, DONE.
REQ-019 Each fifo_enable: pix_col increments; at IFM_SIZE-1 wraps to 0 and pix_row increments.
REQ-020 Shift of pixel (r,c) with r>=KERNAL_SIZE-1 and c>=KERNAL_SIZE-1 sets window_valid on next edge, out_row=r-(KERNAL_SIZE-1), out_col=c-(KERNAL_SIZE-1); latency exactly 1 cycle after shift, aligned with FIFO update.
REQ-021 Shift of a pixel outside that region with window_valid low: window_valid stays 0; row-wrap positions (c<KERNAL_SIZE-1) never produce a window.
REQ-022 window_valid & mac_ready: out_count increments; window_valid cleared unless same-cycle shift creates a new window (then stays 1 with new coordinates).
REQ-023 window_valid & ~mac_ready: window_valid, out_row, out_col held; no shift (in_ready=0).
REQ-024 Shift of last pixel (IFM_SIZE-1, IFM_SIZE-1): RUN -> DRAIN.
REQ-025 DRAIN -> DONE when window_valid & mac_ready; DONE asserts done for exactly one cycle, then IDLE.
REQ-026 Residual FIFO contents from prior image never reach a valid window: first window needs (KERNAL_SIZE-1)*IFM_SIZE+KERNAL_SIZE shifts of current image.
REQ-027 Total windows per image = OUT_SIZE*OUT_SIZE (576 default); out_count at done equals this.
REQ-028 in_valid low in RUN: no shift, counters hold, pending window handshake proceeds normally.

Reset
REQ-029 reset asserted (any state, incl. mid-image): state=IDLE, pix_row=pix_col=0, out_count=0, window_valid=0, out_row=out_col=0, done=0, busy=0, in_ready=0 immediately (asynchronous).
REQ-030 After reset release, no fifo_enable until next start.

Verification
REQ-031 Defaults, start, in_valid=1, mac_ready=1 -> first window_valid cycle after 117th shift with out_row=0,out_col=0; 576 windows; done pulse 1 cycle; out_count=576.
REQ-032 Row wrap: pixels (5,0)..(5,3) shifted -> window_valid 0 for each; pixel (5,4) -> window_valid 1, out_row=1,out_col=0.
REQ-033 Backpressure: mac_ready=0 for 10 cycles while window (0,0) valid -> in_ready=0, fifo_enable=0, window/coords held, out_count unchanged; on mac_ready=1 -> out_count=1, next shift resumes.
REQ-034 Random in_valid gaps (50%) and mac_ready gaps (30%) -> windows in raster order, coords match scoreboard, no window lost/duplicated, 576 total.
REQ-035 reset asserted after 300 shifts -> all outputs at REQ-029 values same cycle; subsequent start processes full image correctly (first window after 117 shifts).
REQ-036 start pulsed during RUN -> ignored, counters unaffected; back-to-back images (start in cycle after done) -> each yields 576 windows.
